// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack memory handshake
// and hands words to decode through a single-entry valid/ready buffer.
module fetch_unit #(
    parameter int unsigned        ADDR_W   = 32,
    parameter int unsigned        DATA_W   = 32,
    parameter int unsigned        PC_STEP  = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int unsigned        TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              fault,
    output logic [1:0]        fault_code,
    input  logic              fault_clear
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_TIMEOUT  = 2'd1;
    localparam logic [1:0] FC_MISALIGN = 2'd2;

    localparam int unsigned CNT_W = 16;
    // The last wait cycle that may still end without a fault.
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(PC_STEP - 1);
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic [1:0]        fault_code_q, fault_code_d;

    logic redirect_misaligned;

    assign redirect_misaligned = |(redirect_target & ALIGN_MASK);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        cnt_d        = cnt_q;
        instr_d      = instr_q;
        instr_pc_d   = instr_pc_q;
        fault_code_d = fault_code_q;

        // Redirect outranks ack, ready and timeout everywhere except FAULT.
        if (state_q != ST_FAULT && redirect_valid) begin
            cnt_d = '0;
            if (redirect_misaligned) begin
                state_d      = ST_FAULT;
                fault_code_d = FC_MISALIGN;
            end else begin
                state_d = ST_REQ;
                pc_d    = redirect_target;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (run) begin
                        state_d = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        instr_d    = mem_rdata;
                        instr_pc_d = pc_q;
                        pc_d       = pc_q + STEP;
                        cnt_d      = '0;
                        state_d    = ST_HOLD;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_d        = '0;
                        fault_code_d = FC_TIMEOUT;
                        state_d      = ST_FAULT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (instr_ready) begin
                        state_d = ST_REQ;
                    end
                end
                default: begin
                    if (fault_clear) begin
                        fault_code_d = FC_NONE;
                        cnt_d        = '0;
                        state_d      = ST_REQ;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            cnt_q        <= '0;
            instr_q      <= '0;
            instr_pc_q   <= '0;
            fault_code_q <= FC_NONE;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            cnt_q        <= cnt_d;
            instr_q      <= instr_d;
            instr_pc_q   <= instr_pc_d;
            fault_code_q <= fault_code_d;
        end
    end

    // Outputs decode straight from state so a reset drops them immediately.
    assign mem_req     = (state_q == ST_REQ);
    assign mem_addr    = pc_q;
    assign instr_valid = (state_q == ST_HOLD);
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign fault       = (state_q == ST_FAULT);
    assign fault_code  = fault_code_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected words are queued when an ack is
// driven and checked when the DUT presents a new word on instr.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        fault;
    logic [1:0]  fault_code;
    logic        fault_clear;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic        valid_prev = 1'b0;
    logic [31:0] exp_pc = '0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    // Memory returns a word tagged with its own address.
    assign mem_rdata = 32'h1000_0000 + mem_addr;

    fetch_unit #(
        .ADDR_W(32), .DATA_W(32), .PC_STEP(4), .RESET_PC(32'h0), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst), .run(run),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .fault(fault), .fault_code(fault_code), .fault_clear(fault_clear)
    );

    always @(negedge clk) begin
        if (instr_valid && !valid_prev) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got instr=%h instr_pc=%h, required no word", instr, instr_pc);
            end else begin
                mon_e = sb_q.pop_front();
                if (instr !== mon_e.data || instr_pc !== mon_e.pc) begin
                    errors++;
                    $display("FAIL sb_word: got instr=%h pc=%h, required instr=%h pc=%h",
                             instr, instr_pc, mon_e.data, mon_e.pc);
                end else begin
                    $display("word pc=%h instr=%h ok", instr_pc, instr);
                end
            end
        end
        valid_prev = instr_valid;
    end

    task automatic test_reset();
        rst = 1'b0; run = 1'b0; mem_ack = 1'b0; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_target = '0; fault_clear = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({mem_req, instr_valid, fault} !== 3'b000) begin
            errors++; $display("FAIL rst_flags: got req/valid/fault=%b, required 000", {mem_req, instr_valid, fault});
        end
        checks++;
        if (fault_code !== 2'd0 || mem_addr !== 32'h0) begin
            errors++; $display("FAIL rst_code_addr: got code=%0d addr=%h, required 0 0", fault_code, mem_addr);
        end
        checks++;
        if (instr !== 32'h0 || instr_pc !== 32'h0) begin
            errors++; $display("FAIL rst_instr: got instr=%h pc=%h, required 0 0", instr, instr_pc);
        end
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin
                errors++; $display("FAIL idle_wait: got req=%b addr=%h, required 0 0", mem_req, mem_addr);
            end
        end
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
            errors++; $display("FAIL run_start: got req=%b addr=%h, required 1 0", mem_req, mem_addr);
        end
        exp_pc = 32'h0;
        $display("reset/run done");
    endtask

    task automatic test_zero_wait();
        mem_ack = 1'b1;
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== exp_pc) begin
                errors++; $display("FAIL zw_req: got req=%b addr=%h, required 1 %h", mem_req, mem_addr, exp_pc);
            end
            sb_q.push_back({exp_pc, 32'h1000_0000 + exp_pc});
            exp_pc += 32'd4;
            @(negedge clk);
            checks++;
            if (instr_valid !== 1'b1 || mem_req !== 1'b0) begin
                errors++; $display("FAIL zw_hold: got valid=%b req=%b, required 1 0", instr_valid, mem_req);
            end
            if (i == 3) mem_ack = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_wait_backpressure();
        logic [31:0] hold_pc;
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mem_req !== 1'b1 || instr_valid !== 1'b0) begin
                errors++; $display("FAIL ws_wait: got req=%b valid=%b, required 1 0", mem_req, instr_valid);
            end
            @(negedge clk);
        end
        mem_ack = 1'b1;
        hold_pc = exp_pc;
        sb_q.push_back({exp_pc, 32'h1000_0000 + exp_pc});
        exp_pc += 32'd4;
        @(negedge clk);
        mem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (instr_valid !== 1'b1 || mem_req !== 1'b0 || mem_addr !== exp_pc ||
                instr !== 32'h1000_0000 + hold_pc || instr_pc !== hold_pc) begin
                errors++;
                $display("FAIL bp_hold: got valid=%b req=%b addr=%h instr=%h pc=%h, required 1 0 %h %h %h",
                         instr_valid, mem_req, mem_addr, instr, instr_pc, exp_pc, 32'h1000_0000 + hold_pc, hold_pc);
            end
            if (i < 4) @(negedge clk);
        end
        instr_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== exp_pc) begin
            errors++; $display("FAIL bp_release: got valid=%b req=%b addr=%h, required 0 1 %h",
                               instr_valid, mem_req, mem_addr, exp_pc);
        end
    endtask

    task automatic test_redirect();
        instr_ready = 1'b0;
        mem_ack = 1'b1;
        sb_q.push_back({exp_pc, 32'h1000_0000 + exp_pc});
        exp_pc += 32'd4;
        @(negedge clk);
        mem_ack = 1'b0;
        redirect_valid = 1'b1;
        redirect_target = 32'h40;
        @(negedge clk);
        redirect_valid = 1'b0;
        exp_pc = 32'h40;
        checks++;
        if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== exp_pc) begin
            errors++; $display("FAIL redir_hold: got valid=%b req=%b addr=%h, required 0 1 %h",
                               instr_valid, mem_req, mem_addr, exp_pc);
        end
        // Ack in the same cycle as a redirect: that word must never surface.
        mem_ack = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 32'h80;
        @(negedge clk);
        mem_ack = 1'b0;
        redirect_valid = 1'b0;
        exp_pc = 32'h80;
        checks++;
        if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== exp_pc) begin
            errors++; $display("FAIL redir_ack: got valid=%b req=%b addr=%h, required 0 1 %h",
                               instr_valid, mem_req, mem_addr, exp_pc);
        end
        mem_ack = 1'b1;
        instr_ready = 1'b1;
        sb_q.push_back({exp_pc, 32'h1000_0000 + exp_pc});
        exp_pc += 32'd4;
        @(negedge clk);
        mem_ack = 1'b0;
        checks++;
        if (instr_valid !== 1'b1) begin
            errors++; $display("FAIL redir_fetch: got valid=%b, required 1", instr_valid);
        end
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== exp_pc) begin
            errors++; $display("FAIL redir_next: got req=%b addr=%h, required 1 %h", mem_req, mem_addr, exp_pc);
        end
    endtask

    task automatic test_misaligned();
        redirect_valid = 1'b1;
        redirect_target = 32'h42;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++;
        if (fault !== 1'b1 || fault_code !== 2'd2 || mem_req !== 1'b0 ||
            instr_valid !== 1'b0 || mem_addr !== exp_pc) begin
            errors++; $display("FAIL misalign: got fault=%b code=%0d req=%b valid=%b addr=%h, required 1 2 0 0 %h",
                               fault, fault_code, mem_req, instr_valid, mem_addr, exp_pc);
        end
        redirect_valid = 1'b1;
        redirect_target = 32'h100;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++;
        if (fault !== 1'b1 || fault_code !== 2'd2 || mem_addr !== exp_pc) begin
            errors++; $display("FAIL fault_redir: got fault=%b code=%0d addr=%h, required 1 2 %h",
                               fault, fault_code, mem_addr, exp_pc);
        end
        fault_clear = 1'b1;
        @(negedge clk);
        fault_clear = 1'b0;
        checks++;
        if (fault !== 1'b0 || fault_code !== 2'd0 || mem_req !== 1'b1 || mem_addr !== exp_pc) begin
            errors++; $display("FAIL fault_clear: got fault=%b code=%0d req=%b addr=%h, required 0 0 1 %h",
                               fault, fault_code, mem_req, mem_addr, exp_pc);
        end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (mem_req !== 1'b1 || fault !== 1'b0) begin
                errors++; $display("FAIL to_wait%0d: got req=%b fault=%b, required 1 0", i, mem_req, fault);
            end
            @(negedge clk);
        end
        checks++;
        if (fault !== 1'b1 || fault_code !== 2'd1 || mem_req !== 1'b0) begin
            errors++; $display("FAIL timeout: got fault=%b code=%0d req=%b, required 1 1 0", fault, fault_code, mem_req);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({mem_req, instr_valid, fault} !== 3'b000 || fault_code !== 2'd0 ||
            mem_addr !== 32'h0 || instr !== 32'h0 || instr_pc !== 32'h0) begin
            errors++; $display("FAIL async_rst: got req=%b valid=%b fault=%b code=%0d addr=%h instr=%h pc=%h, required all 0",
                               mem_req, instr_valid, fault, fault_code, mem_addr, instr, instr_pc);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_idle_redirect();
        run = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0) begin
            errors++; $display("FAIL idle_again: got req=%b, required 0", mem_req);
        end
        redirect_valid = 1'b1;
        redirect_target = 32'h200;
        @(negedge clk);
        redirect_valid = 1'b0;
        exp_pc = 32'h200;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== exp_pc) begin
            errors++; $display("FAIL idle_redir: got req=%b addr=%h, required 1 %h", mem_req, mem_addr, exp_pc);
        end
        mem_ack = 1'b1;
        instr_ready = 1'b1;
        sb_q.push_back({exp_pc, 32'h1000_0000 + exp_pc});
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL sb_drain: got %0d words pending, required 0", sb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_backpressure();
        test_redirect();
        test_misaligned();
        test_timeout();
        test_idle_redirect();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction-fetch stage, the next-generation replacement for the fixed single-cycle PC/instruction latch in the multicycle CPU.
- Owns the program counter.
- Issues requests to the memory subsystem over a req/ack handshake that tolerates variable wait states.
- Presents fetched words to the control/decode stage over a valid/ready handshake.
- Adds redirect (branch/jump) handling, misalignment detection and a bus-timeout fault.

Parameters:
ADDR_W, 32, width of PC and memory address
DATA_W, 32, instruction word width
PC_STEP, 4, sequential PC increment; must be a power of two
RESET_PC, 0, PC value loaded on reset
TIMEOUT, 255, max cycles in REQ without mem_ack before fault; range 1..65535

Ports:
clk  in  1  system clock; all state changes on rising edge
rst  in  1  asynchronous active-low reset
run  in  1  fetch enable; sampled only in IDLE
mem_req  out  1  memory read request
mem_addr  out  ADDR_W  request address; equals pc
mem_ack  in  1  memory has valid data on mem_rdata this cycle
mem_rdata  in  DATA_W  memory read data
instr_valid  out  1  instr/instr_pc hold a valid fetched word
instr  out  DATA_W  fetched instruction
instr_pc  out  ADDR_W  address instr was fetched from
instr_ready  in  1  consumer accepts instr this cycle
redirect_valid  in  1  load new PC
redirect_target  in  ADDR_W  new PC value
fault  out  1  fetch unit halted on error
fault_code  out  2  0 none, 1 timeout, 2 misaligned redirect
fault_clear  in  1  leave FAULT and retry at current pc

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC, state=IDLE, timeout counter=0.
  - instr=0, instr_pc=0, instr_valid=0, fault=0, fault_code=0, mem_req=0.
- States: IDLE, REQ, HOLD, FAULT. Encode as a 2-bit registered state. mem_req=1 iff state==REQ. mem_addr=pc in all states.
- IDLE: if run=1, go to REQ next cycle; otherwise stay.
- REQ:
  - The counter increments each cycle mem_ack=0.
  - mem_ack=1 at a rising edge: instr<=mem_rdata, instr_pc<=pc, pc<=pc+PC_STEP (wraps mod 2^ADDR_W), counter<=0, go to HOLD.
  - Minimum fetch latency: mem_req rises cycle N, data captured at end of cycle N if ack in the same cycle; instr_valid high from cycle N+1.
  - Counter reaching TIMEOUT with mem_ack=0: go to FAULT with fault_code=1.
- HOLD:
  - instr_valid=1; instr and instr_pc are stable.
  - instr_ready=1: go to REQ next cycle; instr_valid drops that cycle.
  - No fetch is outstanding while in HOLD; single-entry buffer.
- Redirect (any state except FAULT) has priority over mem_ack, instr_ready and timeout:
  - If redirect_target mod PC_STEP != 0: go to FAULT, fault_code=2, pc unchanged.
  - Otherwise: pc<=redirect_target, counter<=0, instr_valid cleared next cycle, go to REQ.
  - A mem_ack coinciding with redirect is discarded; instr is not updated.
  - Redirect in IDLE goes to REQ regardless of run.
- FAULT:
  - mem_req=0, instr_valid=0, fault=1; fault_code is held.
  - redirect_valid is ignored.
  - fault_clear=1: fault<=0, fault_code<=0, counter<=0, go to REQ at the current pc.
- Reset mid-operation aborts any pending request immediately; mem_req drops asynchronously.
- run=0 after leaving IDLE has no effect. Only reset returns the unit to IDLE.

Test Plan:
- Reset/run: hold rst=0, then release with run=0 for 5 cycles → mem_req=0, mem_addr=0. Set run=1 → mem_req=1 next cycle with mem_addr=0.
- Zero-wait fetch: mem_ack tied 1, mem_rdata=0x1000_0000+addr, instr_ready=1 → instr_pc sequence 0,4,8,12, one fetch every 2 cycles, instr matches.
- Wait states and backpressure: ack after 3 cycles, instr_ready held 0 for 4 cycles → instr/instr_valid stable throughout HOLD, no new mem_req, pc=4 while holding.
- Redirect: in HOLD at instr_pc=8, pulse redirect_target=0x40 → instr_valid=0 next cycle, next mem_addr=0x40. Redirect coincident with mem_ack → that data never appears on instr.
- Misaligned redirect: redirect_target=0x42 → fault=1, fault_code=2, mem_req=0. Assert fault_clear → mem_req=1 at the previous pc.
- Timeout: TIMEOUT=8, never ack → fault=1, fault_code=1 after 8 REQ cycles. Assert rst=0 mid-FAULT → all outputs return to reset values.
